equilibrium_score_engine: RTL and testbench
===========================================

EQUILIBRIUM_SCORE_ENGINE -- requirements
Module: equilibrium_score_engine

Interface
REQ-001 Parameter NUM_ZONES, default 8: number of LED target zones.
REQ-002 Parameter POS_W, default 16: signed pendulum position width.
REQ-003 Parameter ZONE_MIN, default -1024: signed lower bound of zone 0.
REQ-004 Parameter ZONE_SPAN, default 256: positions per zone.
REQ-005 Parameter DWELL_BASE, default 4: dwell ticks unit.
REQ-006 Parameter ROUND_BASE, default 256: round length in ticks at level 0.
REQ-007 Parameter SCORE_W, default 10: score width.
REQ-008 clock  in  1  system clock; all state on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 start_round  in  1  one-cycle pulse; latches target and level, starts round.
REQ-011 target_zone  in  clog2(NUM_ZONES)  zone index from random LED generator.
REQ-012 nivel_dificuldade  in  2  difficulty level 0..3.
REQ-013 tick  in  1  game time-base pulse; counters and position sampling advance only when high.
REQ-014 current_pos  in  POS_W signed  pendulum position.
REQ-015 clear_score  in  1  synchronous score/streak clear.
REQ-016 ganhou_ponto / perdeu_ponto  out  1 each  one-cycle win/loss pulses.
REQ-017 pontuacao  out  SCORE_W  accumulated score.
REQ-018 round_active  out  1  high in SEEK or HOLD.
REQ-019 in_zone  out  1  registered: last sampled position inside latched zone.
REQ-020 streak  out  3  consecutive-win count.

Function
REQ-021 FSM states IDLE, SEEK, HOLD, RESULT; SHALL be encoded as a registered state.
REQ-022 start_round in any state SHALL latch target (clamped to NUM_ZONES-1) and level, clear round and dwell counters, enter SEEK next cycle.
REQ-023 Zone k SHALL be ZONE_MIN+k*ZONE_SPAN <= pos <= ZONE_MIN+(k+1)*ZONE_SPAN-1, signed compare, widened to avoid overflow.
REQ-024 Dwell requirement SHALL be DWELL_BASE*(level+1); round limit SHALL be ROUND_BASE>>level.
REQ-025 Each tick in SEEK/HOLD SHALL increment the round counter; in-zone sample SHALL increment dwell (SEEK->HOLD on first), out-of-zone sample SHALL zero dwell and return HOLD->SEEK.
REQ-026 Dwell reaching requirement SHALL enter RESULT as win; round counter reaching limit SHALL enter RESULT as loss; both on same tick SHALL count as win.
REQ-027 RESULT SHALL last one cycle, asserting exactly one of ganhou_ponto/perdeu_ponto, then go to IDLE.
REQ-028 Win SHALL add level+1 to pontuacao, saturating at 2^SCORE_W-1; loss SHALL leave score unchanged.
REQ-029 Win SHALL increment streak (saturate 7); loss SHALL zero streak.
REQ-030 clear_score SHALL zero pontuacao and streak; simultaneous with a win, clear SHALL take priority.
REQ-031 start_round during RESULT SHALL still emit that cycle's pulse, then enter SEEK.
REQ-032 tick with no start_round in IDLE SHALL have no effect.

Reset
REQ-033 reset SHALL immediately force IDLE, all counters, pontuacao, streak, in_zone, pulses, latched target/level to 0, including mid-round.

Configuration
REQ-034 Macro SCORE_STREAK_EN: defined, a win with streak>=3 (before increment) SHALL add one extra point (saturating); undefined, no bonus, streak output SHALL be tied to 0 and streak logic omitted.

Verification
REQ-035 Level 0, target 4, pos 0 held, ticks every cycle -> 4 ticks after start ganhou_ponto pulse, pontuacao 0->1.
REQ-036 Level 3, target 0, pos 500 -> perdeu_ponto after 32 ticks, pontuacao unchanged, streak 0.
REQ-037 Level 1, target 2, pos toggles in/out every 3 ticks -> dwell never reaches 8, loss after 128 ticks.
REQ-038 pontuacao 1022, level 3 win -> pontuacao 1023 (saturated); clear_score with win same cycle -> 0.
REQ-039 SCORE_STREAK_EN defined, four level-0 wins -> scores 1,2,3,5; undefined -> 1,2,3,4.
REQ-040 reset asserted in HOLD at dwell 2 -> IDLE, all outputs 0 asynchronously; target_zone 15 -> clamped to zone 7.

Source files
------------

// File: rtl/equilibrium_score_engine_if.sv
// Signal bundle between the game controller (master) and equilibrium_score_engine (slave).
interface equilibrium_score_engine_if #(
  parameter int NUM_ZONES = 8,
  parameter int POS_W     = 16,
  parameter int SCORE_W   = 10
);
  localparam int TZ_W = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

  // No valid/ready pair here: start_round, tick and clear_score are single-cycle
  // strobes sampled on the rising clock edge, and ganhou_ponto/perdeu_ponto are
  // single-cycle strobes the consumer must take on the cycle they are high.
  logic                      start_round;
  logic [TZ_W-1:0]           target_zone;
  logic [1:0]                nivel_dificuldade;
  logic                      tick;
  logic signed [POS_W-1:0]   current_pos;
  logic                      clear_score;
  logic                      ganhou_ponto;
  logic                      perdeu_ponto;
  logic [SCORE_W-1:0]        pontuacao;
  logic                      round_active;
  logic                      in_zone;
  logic [2:0]                streak;

  modport master (
    output start_round, target_zone, nivel_dificuldade, tick, current_pos, clear_score,
    input  ganhou_ponto, perdeu_ponto, pontuacao, round_active, in_zone, streak
  );

  modport slave (
    input  start_round, target_zone, nivel_dificuldade, tick, current_pos, clear_score,
    output ganhou_ponto, perdeu_ponto, pontuacao, round_active, in_zone, streak
  );
endinterface

// File: rtl/equilibrium_score_engine.sv
// Pendulum balance game: hold the pendulum inside a target LED zone long enough to score.
// Optional macro SCORE_STREAK_EN adds a win-streak counter and a bonus point at streak >= 3.
module equilibrium_score_engine #(
  parameter int NUM_ZONES  = 8,
  parameter int POS_W      = 16,
  parameter int ZONE_MIN   = -1024,
  parameter int ZONE_SPAN  = 256,
  parameter int DWELL_BASE = 4,
  parameter int ROUND_BASE = 256,
  parameter int SCORE_W    = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  equilibrium_score_engine_if.slave   sif,
  output logic [1:0]                  o_dbg_state
);
  localparam int TZ_W = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam int RC_W = $clog2(ROUND_BASE + 1);
  localparam int DC_W = $clog2(DWELL_BASE * 4 + 1);
  localparam int CW   = POS_W + 34;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEEK   = 2'd1,
    S_HOLD   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t            r_state;
  logic [TZ_W-1:0]   r_target;
  logic [1:0]        r_level;
  logic [RC_W-1:0]   r_round;
  logic [DC_W-1:0]   r_dwell;
  logic              r_in_zone;
  logic              r_win;
  logic              r_loss;
  logic [SCORE_W-1:0] r_score;

  logic signed [CW-1:0] w_pos;
  logic signed [CW-1:0] w_lo;
  logic signed [CW-1:0] w_hi;
  logic                 w_in_zone;
  logic [DC_W-1:0]      w_dwell_req;
  logic [RC_W-1:0]      w_round_lim;
  logic [DC_W-1:0]      w_dwell_inc;
  logic [RC_W-1:0]      w_round_inc;
  logic                 w_hit;
  logic                 w_timeout;
  logic                 w_sample;
  logic                 w_win_evt;
  logic                 w_loss_evt;
  logic                 w_bonus;
  logic [3:0]           w_pts;
  logic [SCORE_W:0]     w_sum;
  logic [SCORE_W-1:0]   w_score_sat;

  // Zone bounds are computed far wider than POS_W so extreme parameters cannot wrap.
  assign w_pos     = {{(CW-POS_W){sif.current_pos[POS_W-1]}}, sif.current_pos};
  assign w_lo      = CW'(ZONE_MIN) + CW'(r_target) * CW'(ZONE_SPAN);
  assign w_hi      = w_lo + CW'(ZONE_SPAN) - CW'(1);
  assign w_in_zone = (w_pos >= w_lo) && (w_pos <= w_hi);

  assign w_dwell_req = DC_W'(DWELL_BASE * (int'(r_level) + 1));
  assign w_round_lim = RC_W'(ROUND_BASE >> r_level);
  assign w_dwell_inc = r_dwell + DC_W'(1);
  assign w_round_inc = r_round + RC_W'(1);
  assign w_hit       = w_in_zone && (w_dwell_inc >= w_dwell_req);
  assign w_timeout   = (w_round_inc >= w_round_lim);

  assign w_sample   = !sif.start_round && sif.tick &&
                      ((r_state == S_SEEK) || (r_state == S_HOLD));
  assign w_win_evt  = w_sample && w_hit;
  assign w_loss_evt = w_sample && !w_hit && w_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_target  <= '0;
      r_level   <= '0;
      r_round   <= '0;
      r_dwell   <= '0;
      r_in_zone <= 1'b0;
      r_win     <= 1'b0;
      r_loss    <= 1'b0;
    end else begin
      r_win  <= 1'b0;
      r_loss <= 1'b0;
      if (sif.start_round) begin
        if ({1'b0, sif.target_zone} > (TZ_W+1)'(NUM_ZONES - 1))
          r_target <= TZ_W'(NUM_ZONES - 1);
        else
          r_target <= sif.target_zone;
        r_level   <= sif.nivel_dificuldade;
        r_round   <= '0;
        r_dwell   <= '0;
        r_in_zone <= 1'b0;
        r_state   <= S_SEEK;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_SEEK, S_HOLD: begin
            if (sif.tick) begin
              r_round   <= w_round_inc;
              r_in_zone <= w_in_zone;
              r_dwell   <= w_in_zone ? w_dwell_inc : '0;
              // A dwell win on the final round tick still counts as a win.
              if (w_hit) begin
                r_state <= S_RESULT;
                r_win   <= 1'b1;
              end else if (w_timeout) begin
                r_state <= S_RESULT;
                r_loss  <= 1'b1;
              end else begin
                r_state <= w_in_zone ? S_HOLD : S_SEEK;
              end
            end
          end
          S_RESULT: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SCORE_STREAK_EN
  logic [2:0] r_streak;

  assign w_bonus = (r_streak >= 3'd3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_streak <= '0;
    else if (sif.clear_score || w_loss_evt)
      r_streak <= '0;
    else if (w_win_evt && (r_streak != 3'd7))
      r_streak <= r_streak + 3'd1;
  end

  assign sif.streak = r_streak;
`else
  assign w_bonus    = 1'b0;
  assign sif.streak = 3'd0;
`endif

  assign w_pts       = 4'(r_level) + 4'd1 + 4'(w_bonus);
  assign w_sum       = {1'b0, r_score} + (SCORE_W+1)'(w_pts);
  assign w_score_sat = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

  // Clearing wins over a same-cycle scoring event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_score <= '0;
    else if (sif.clear_score)
      r_score <= '0;
    else if (w_win_evt)
      r_score <= w_score_sat;
  end

  assign sif.ganhou_ponto = r_win;
  assign sif.perdeu_ponto = r_loss;
  assign sif.pontuacao    = r_score;
  assign sif.round_active = (r_state == S_SEEK) || (r_state == S_HOLD);
  assign sif.in_zone      = r_in_zone;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_equilibrium_score_engine.sv
// Directed self-checking bench for equilibrium_score_engine with a result scoreboard.
module tb_equilibrium_score_engine;
  localparam int NUM_ZONES = 8;
  localparam int POS_W     = 16;
  localparam int SCORE_W   = 10;
  localparam int TZ_W      = $clog2(NUM_ZONES);
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
  localparam int EW        = 1 + 16 + SCORE_W + 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  equilibrium_score_engine_if #(.NUM_ZONES(NUM_ZONES), .POS_W(POS_W), .SCORE_W(SCORE_W)) sif ();

  equilibrium_score_engine dut (
    .clock       (clock),
    .reset       (reset),
    .sif         (sif.slave),
    .o_dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int m_score = 0;
  int m_streak = 0;
  bit sparse = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_result(input int lvl, input bit win, input bit clr);
    int pts;
    if (clr) begin
      m_score  = 0;
      m_streak = 0;
    end else if (win) begin
      pts = lvl + 1;
`ifdef SCORE_STREAK_EN
      if (m_streak >= 3) pts++;
      m_streak = (m_streak < 7) ? m_streak + 1 : 7;
`endif
      m_score = (m_score + pts > SCORE_MAX) ? SCORE_MAX : m_score + pts;
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic do_start(input int lvl, input int tgt);
    logic [31:0] tz;
    tz = tgt;
    sif.start_round       = 1'b1;
    sif.target_zone       = tz[TZ_W-1:0];
    sif.nivel_dificuldade = 2'(lvl);
    sif.tick              = 1'b0;
    @(negedge clock);
    sif.start_round = 1'b0;
    chk("start_active", sif.round_active, 1);
    chk("start_pulses_low", {sif.ganhou_ponto, sif.perdeu_ponto}, 0);
  endtask

  // mode 0: constant pos_a; mode 1: pos_a/pos_b every 3 ticks; mode 2: zone-7 boundary walk
  task automatic run_round(input int lvl, input int tgt, input int mode, input int pos_a,
                           input int pos_b, input bit clr_on_win, input bit exp_win,
                           input int exp_ticks);
    int ticks;
    int cyc;
    int p;
    bit done;
    logic [EW-1:0] e;
    model_result(lvl, exp_win, clr_on_win && exp_win);
    exp_q.push_back({exp_win, 16'(exp_ticks), SCORE_W'(m_score), 3'(m_streak)});
    do_start(lvl, tgt);
    ticks = 0;
    cyc   = 0;
    done  = 1'b0;
    while (!done && cyc < 800) begin
      sif.tick = sparse ? 1'($urandom_range(0, 1)) : 1'b1;
      case (mode)
        0:       p = pos_a;
        1:       p = (((ticks / 3) % 2) == 0) ? pos_a : pos_b;
        default: p = (ticks == 0) ? 767 : (ticks == 1) ? 768 : (ticks == 2) ? 1023 :
                     (ticks == 3) ? 1024 : 768;
      endcase
      sif.current_pos = POS_W'(p);
      sif.clear_score = clr_on_win && sif.tick && (ticks == exp_ticks - 1);
      @(negedge clock);
      cyc++;
      if (sif.tick) ticks++;
      if (sif.ganhou_ponto || sif.perdeu_ponto) done = 1'b1;
      if (mode == 2 && sif.tick && ticks <= 4 && !done)
        chk("boundary_in_zone", sif.in_zone, (ticks == 2 || ticks == 3) ? 1 : 0);
    end
    sif.tick        = 1'b0;
    sif.clear_score = 1'b0;
    chk("round_finished", done, 1);
    e = exp_q.pop_front();
    if (done) begin
      chk("win_pulse", sif.ganhou_ponto, e[EW-1]);
      chk("loss_pulse", sif.perdeu_ponto, !e[EW-1]);
      chk("result_ticks", ticks, e[EW-2 -: 16]);
      chk("score", sif.pontuacao, e[3 +: SCORE_W]);
      chk("streak", sif.streak, e[2:0]);
      chk("result_inactive", sif.round_active, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_active"}, sif.round_active, 0);
    chk({tag, "_pulses"}, {sif.ganhou_ponto, sif.perdeu_ponto}, 0);
    chk({tag, "_score"}, sif.pontuacao, m_score);
    chk({tag, "_streak"}, sif.streak, m_streak);
  endtask

  initial begin
    int exp4;
    reset                 = 1'b1;
    sif.start_round       = 1'b0;
    sif.target_zone       = '0;
    sif.nivel_dificuldade = '0;
    sif.tick              = 1'b0;
    sif.current_pos       = '0;
    sif.clear_score       = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle("reset");
    chk("reset_in_zone", sif.in_zone, 0);
    chk("reset_state", dbg_state, 0);

    // Ticks without a start leave the engine idle.
    sif.tick = 1'b1;
    repeat (5) @(negedge clock);
    sif.tick = 1'b0;
    check_idle("idle_ticks");

    run_round(0, 4, 0, 0, 0, 1'b0, 1'b1, 4);
    run_round(3, 0, 0, 500, 0, 1'b0, 1'b0, 32);
    run_round(1, 2, 1, -400, 500, 1'b0, 1'b0, 128);
    run_round(3, 7, 2, 0, 0, 1'b0, 1'b1, 20);
    run_round(0, 0, 0, -1024, 0, 1'b0, 1'b1, 4);
    @(negedge clock);
    check_idle("after_results");

    sif.clear_score = 1'b1;
    @(negedge clock);
    sif.clear_score = 1'b0;
    model_result(0, 1'b0, 1'b1);
    check_idle("clear");

    for (int i = 0; i < 4; i++) run_round(0, 4, 0, 0, 0, 1'b0, 1'b1, 4);
`ifdef SCORE_STREAK_EN
    exp4 = 5;
`else
    exp4 = 4;
`endif
    chk("four_wins_score", sif.pontuacao, exp4);

    sparse = 1'b1;
    run_round(2, 4, 0, 100, 0, 1'b0, 1'b1, 12);
    run_round(3, 0, 0, 500, 0, 1'b0, 1'b0, 32);
    sparse = 1'b0;

    // Restart mid-round: dwell from the aborted round must not carry over.
    do_start(1, 4);
    sif.tick        = 1'b1;
    sif.current_pos = POS_W'(10);
    repeat (3) @(negedge clock);
    run_round(0, 4, 0, 10, 0, 1'b0, 1'b1, 4);

    sif.clear_score = 1'b1;
    @(negedge clock);
    sif.clear_score = 1'b0;
    model_result(0, 1'b0, 1'b1);
    while (m_score < 1020) run_round(3, 4, 0, 0, 0, 1'b0, 1'b1, 16);
    run_round(1, 4, 0, 0, 0, 1'b0, 1'b1, 8);
`ifndef SCORE_STREAK_EN
    chk("score_1022", sif.pontuacao, 1022);
`endif
    run_round(3, 4, 0, 0, 0, 1'b0, 1'b1, 16);
    chk("score_saturated", sif.pontuacao, SCORE_MAX);
    run_round(0, 4, 0, 0, 0, 1'b1, 1'b1, 4);
    chk("clear_beats_win", sif.pontuacao, 0);
    run_round(0, 4, 0, 0, 0, 1'b0, 1'b1, 4);

    // Asynchronous reset while holding at dwell 2.
    do_start(0, 4);
    sif.tick        = 1'b1;
    sif.current_pos = POS_W'(0);
    repeat (2) @(negedge clock);
    sif.tick = 1'b0;
    chk("hold_state", dbg_state, 2);
    chk("hold_in_zone", sif.in_zone, 1);
    #2 reset = 1'b1;
    #1;
    m_score  = 0;
    m_streak = 0;
    check_idle("async_reset");
    chk("async_reset_in_zone", sif.in_zone, 0);
    chk("async_reset_state", dbg_state, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_round(3, 15, 2, 0, 0, 1'b0, 1'b1, 20);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
